// File: rtl/tx_pattern_gen.sv
// Parallel TX test-pattern source: counter, walking one, PRBS-7 (x^7+x^6+1) or 0x55/0xAA words.
// One cycle from en to valid; no backpressure, en=0 freezes the word and the generator state.
module tx_pattern_gen #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter int              STEP      = 1,
    parameter logic [6:0]      PRBS_SEED = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_CNT  = 2'b00,
        MODE_WALK = 2'b01,
        MODE_PRBS = 2'b10,
        MODE_ALT  = 2'b11
    } mode_e;

    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = (i % 2 == 0);
        end
        return w;
    endfunction

    localparam logic [WIDTH-1:0] ALT_WORD = alt_pattern();
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    function automatic logic [WIDTH-1:0] start_word(input mode_e m);
        case (m)
            MODE_CNT:  return INIT;
            MODE_WALK: return WIDTH'(1);
            MODE_PRBS: return '0;
            default:   return ALT_WORD;
        endcase
    endfunction

    logic [WIDTH-1:0] word_q;
    logic [6:0]       lfsr_q;
    mode_e            mode_q;
    logic             restart_q;

    mode_e            mode_in;
    mode_e            cur_mode;
    logic             mode_chg;
    logic [WIDTH-1:0] cur_word;
    logic [6:0]       cur_lfsr;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] prbs_word;
    logic [6:0]       prbs_lfsr;
    logic             fb;
    logic [WIDTH-1:0] nxt_word;
    logic [6:0]       nxt_lfsr;
    logic             wrap_nxt;

    // Until the first word after reset, the generator behaves as if freshly loaded
    // with the start value of whatever mode is currently selected.
    always_comb begin
        mode_in   = mode_e'(mode);
        cur_mode  = restart_q ? mode_in : mode_q;
        mode_chg  = !restart_q && (mode_in != mode_q);
        cur_word  = restart_q ? start_word(mode_in) : word_q;
        cur_lfsr  = restart_q ? PRBS_SEED : lfsr_q;
        sum       = {1'b0, cur_word} + {1'b0, STEP_W};
        prbs_word = cur_word;
        prbs_lfsr = cur_lfsr;
        fb        = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            fb        = prbs_lfsr[6] ^ prbs_lfsr[5];
            prbs_lfsr = {prbs_lfsr[5:0], fb};
            prbs_word = {prbs_word[WIDTH-2:0], fb};
        end
        nxt_lfsr = cur_lfsr;
        case (cur_mode)
            MODE_CNT: begin
                nxt_word = sum[WIDTH-1:0];
                wrap_nxt = sum[WIDTH];
            end
            MODE_WALK: begin
                nxt_word = {cur_word[WIDTH-2:0], cur_word[WIDTH-1]};
                wrap_nxt = cur_word[WIDTH-1];
            end
            MODE_PRBS: begin
                nxt_word = prbs_word;
                nxt_lfsr = prbs_lfsr;
                wrap_nxt = (prbs_lfsr == PRBS_SEED);
            end
            default: begin
                nxt_word = ~cur_word;
                wrap_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            word_q    <= '0;
            lfsr_q    <= PRBS_SEED;
            mode_q    <= MODE_CNT;
            restart_q <= 1'b1;
        end else if (mode_chg) begin
            word_q <= start_word(mode_in);
            lfsr_q <= PRBS_SEED;
            mode_q <= mode_in;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else if (en) begin
            count     <= cur_word;
            valid     <= 1'b1;
            wrap      <= wrap_nxt;
            word_q    <= nxt_word;
            lfsr_q    <= nxt_lfsr;
            mode_q    <= cur_mode;
            restart_q <= 1'b0;
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Directed bench for tx_pattern_gen: word-index reference model checked every cycle,
// plus literal spot values for reset, each pattern, wrap points, mode change and async reset.
module tb_tx_pattern_gen;

    localparam int         W       = 8;
    localparam logic [7:0] P_INIT  = 8'h00;
    localparam int         P_STEP  = 1;
    localparam logic [6:0] P_SEED  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] count;
    logic       valid;
    logic       wrap;

    tx_pattern_gen #(
        .WIDTH(W), .INIT(P_INIT), .STEP(P_STEP), .PRBS_SEED(P_SEED)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .count(count), .valid(valid), .wrap(wrap)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Bit-serial PRBS-7 reference: generated bit n and LFSR contents after n steps.
    bit         gen_bits [0:4095];
    logic [6:0] lfsr_at  [0:4096];

    initial begin
        logic [6:0] l;
        logic       b;
        l = P_SEED;
        lfsr_at[0] = l;
        for (int n = 0; n < 4096; n++) begin
            b = l[6] ^ l[5];
            gen_bits[n] = b;
            l = {l[5:0], b};
            lfsr_at[n+1] = l;
        end
    end

    // Word k of a pattern, counted from the start value (k = 0).
    function automatic logic [7:0] model_word(input logic [1:0] m, input int k);
        logic [7:0] w;
        w = 8'h00;
        case (m)
            2'b00: w = 8'((int'(P_INIT) + k * P_STEP) % 256);
            2'b01: w = 8'(1 << (k % 8));
            2'b10: if (k > 0 && k < 500)
                       for (int j = 0; j < 8; j++) w[7-j] = gen_bits[(k-1)*8 + j];
            default: w = (k % 2 == 0) ? 8'h55 : 8'hAA;
        endcase
        return w;
    endfunction

    function automatic logic model_wrap(input logic [1:0] m, input int k);
        case (m)
            2'b00:   return ((int'(P_INIT) + k * P_STEP) % 256 + P_STEP) >= 256;
            2'b01:   return (k % 8) == 7;
            2'b10:   return (k < 500) && (lfsr_at[(k+1)*8] == P_SEED);
            default: return 1'b0;
        endcase
    endfunction

    logic [1:0] m_mode    = 2'b00;
    int         m_k       = 0;
    logic [7:0] exp_word  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_wrap  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode    = mode;
            m_k       = 0;
            exp_word  = 8'h00;
            exp_valid = 1'b0;
            exp_wrap  = 1'b0;
        end else if (mode != m_mode) begin
            m_mode    = mode;
            m_k       = 0;
            exp_valid = 1'b0;
            exp_wrap  = 1'b0;
        end else if (en) begin
            exp_word  = model_word(m_mode, m_k);
            exp_wrap  = model_wrap(m_mode, m_k);
            exp_valid = 1'b1;
            m_k++;
        end else begin
            exp_valid = 1'b0;
            exp_wrap  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid", valid, exp_valid);
            check("count", count, exp_word);
            check("wrap",  wrap,  exp_wrap);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_on = 1'b1;
        cyc(2);
        check("rst_count", count, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_wrap",  wrap,  1'b0);
        rst = 1'b1;

        // Counter mode, full period.
        en = 1'b1;
        cyc(1);   check("cnt_first", count, 8'h00); check("cnt_first_vld", valid, 1'b1);
        cyc(1);   check("cnt_second", count, 8'h01);
        cyc(254); check("cnt_255", count, 8'hFF); check("cnt_255_wrap", wrap, 1'b1);
        cyc(1);   check("cnt_roll", count, 8'h00); check("cnt_roll_wrap", wrap, 1'b0);

        // en pattern 1,1,0,0,1.
        cyc(2);   check("en_word2", count, 8'h02);
        en = 1'b0;
        cyc(2);   check("en_hold", count, 8'h02); check("en_hold_vld", valid, 1'b0);
        en = 1'b1;
        cyc(1);   check("en_resume", count, 8'h03);

        // Walking one.
        mode = 2'b01;
        cyc(1);   check("walk_chg_vld", valid, 1'b0); check("walk_chg_cnt", count, 8'h03);
        cyc(8);   check("walk_80", count, 8'h80); check("walk_80_wrap", wrap, 1'b1);
        cyc(1);   check("walk_back", count, 8'h01);

        // Alternating.
        mode = 2'b11;
        cyc(1);
        cyc(2);   check("alt_aa", count, 8'hAA); check("alt_wrap", wrap, 1'b0);
        cyc(3);

        // PRBS-7 over more than two periods.
        mode = 2'b10;
        cyc(1);
        cyc(1);   check("prbs_w0", count, 8'h00);
        cyc(1);   check("prbs_w1", count, 8'h02);
        cyc(1);   check("prbs_w2", count, 8'h0C);
        cyc(124); check("prbs_w126_wrap", wrap, 1'b1);
        cyc(2);   check("prbs_w128", count, 8'h02);
        cyc(130);

        // Counter to 0x23, then switch to walking one.
        mode = 2'b00;
        cyc(1);
        cyc(36);  check("cnt_23", count, 8'h23);
        mode = 2'b01;
        cyc(1);   check("sw_vld", valid, 1'b0); check("sw_hold", count, 8'h23);
        cyc(1);   check("sw_start", count, 8'h01); check("sw_start_vld", valid, 1'b1);
        cyc(2);   check("sw_04", count, 8'h04);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b0;
        #1;
        check("arst_count", count, 8'h00);
        check("arst_valid", valid, 1'b0);
        check("arst_wrap",  wrap,  1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);   check("rel_start", count, 8'h01); check("rel_vld", valid, 1'b1);
        cyc(3);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pattern_gen.md
Name: tx_pattern_gen

Overview:
- Parallel test-pattern source for the HPIO TX serializer path, running in the 200 MHz fabric clock domain.
- Produces one WIDTH-bit word per enabled cycle, plus a valid flag and a sequence-wrap marker.
- Patterns: incrementing counter (default), walking one, parallel PRBS-7 and alternating 0x55/0xAA.
- Sits between reset sequencing and the TX data_from_fabric input.

Parameters:
- WIDTH, 8, data word width; legal range 2..32.
- INIT, 0, first counter value after reset or after a change into counter mode.
- STEP, 1, counter increment per enabled cycle, modulo 2^WIDTH.
- PRBS_SEED, 7'h7F, PRBS-7 LFSR seed; must be nonzero.

Ports:
- clk  input  1  fabric clock (200 MHz); all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- en  input  1  advance enable; sampled each rising edge.
- mode  input  2  pattern select: 00 count, 01 walking one, 10 PRBS-7, 11 alternating.
- count  output  WIDTH  current pattern word; registered.
- valid  output  1  count carries a fresh word this cycle; registered.
- wrap  output  1  one-cycle pulse aligned with the last word of a pattern period.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, valid=0, wrap=0.
  - Generator state = start value of the current mode.
  - Registered copy of mode = mode input.
- Start values:
  - count mode: INIT.
  - walking one: 1 (bit0 set).
  - PRBS: LFSR=PRBS_SEED.
  - alternating: 0x55 pattern, i.e. {WIDTH/2{2'b01}}, truncated to WIDTH.
- Datapath: internal state register plus output register.
  - On an edge with en=1: count <= state, valid <= 1, state <= next(state).
  - First valid word after reset is the start value: 1-cycle latency from en to valid.
- en=0 on an edge: count holds, valid <= 0, wrap <= 0, state holds.
- Next-state rules:
  - count: state+STEP, truncated to WIDTH bits (wraps 2^WIDTH-1 -> 0 for STEP=1).
  - walking one: rotate left by 1; MSB returns to bit0.
  - PRBS-7: polynomial x^7+x^6+1, Fibonacci form.
    - Advance exactly WIDTH single-bit steps per enabled cycle.
    - Emitted word = the WIDTH new feedback bits, first-generated bit in the MSB.
    - count is 0 for the first word (state word before any generated bits); define state output as the last WIDTH generated bits, zero for the seed word.
  - alternating: bitwise invert each cycle.
- wrap: registered together with count, asserted with the word that is the final word of its period.
  - count mode: word whose next(state) overflowed past 2^WIDTH (carry out).
  - walking one: word with MSB set.
  - PRBS: word after which the LFSR equals PRBS_SEED again.
  - alternating: 0.
- Mode change: the mode register is compared with the mode input on each edge.
  - If they differ: state reloads the new mode's start value and the mode register updates. count/valid behave as if en=0 on that edge: no word is output on the change cycle.
  - Next enabled edge outputs the new mode's start value.
- Reset mid-stream: outputs clear immediately (asynchronous); restart on release from start values.
- Release of rst is expected synchronous to clk; no internal synchronizer.

Test Plan:
- Reset, WIDTH=8, INIT=0, STEP=1, mode=00: release rst, hold en=1.
  - count = 0,1,2,…; valid rises 1 cycle after the first en edge.
  - After 256 words count=0 again; wrap=1 with word 255 only.
- en toggling 1,1,0,0,1 in count mode:
  - Words 0,1 then held at 1 with valid=0 for 2 cycles, then 2; no skipped or duplicated values while valid.
- mode=01:
  - count = 01,02,04,…,80,01; wrap=1 with 0x80.
- mode=11:
  - count = 55,AA,55,…; wrap stays 0.
- mode=10, seed 7F:
  - Sequence matches a bit-serial PRBS-7 reference model packed 8 bits/word.
  - wrap after 127 words; period repeats exactly.
- Switch mode 00 to 01 mid-stream at count=0x23, then assert rst=0 mid-stream:
  - One cycle valid=0, then 0x01.
  - On reset, count=0, valid=0 asynchronously, before the next clk edge.
